// File: rtl/execute_stage_mdu_if.sv
// -----------------------------------------------------------------------------
// execute_stage_mdu_if
// Bundles the E-stage decode/operand inputs, the forwarding and stall controls,
// and the M-stage / branch / hazard outputs of the execute stage.
//   slave  : the execute stage (consumes E-stage values, produces M-stage values)
//   master : the surrounding pipeline (drives E-stage values, observes outputs)
// Parameter XLEN sets the datapath width and must match the attached stage.
// -----------------------------------------------------------------------------
interface execute_stage_mdu_if #(
   parameter int XLEN = 32
);
   // E-stage decoded controls
   logic            RegWriteE;
   logic            MemWriteE;
   logic            JumpE;
   logic            BranchE;
   logic            ALUSrcE;
   logic [1:0]      ResultSrcE;
   logic [1:0]      MemSizeE;
   logic [3:0]      ALUCtrlE;
   logic            MdEnE;
   logic [2:0]      MdOpE;
   // E-stage operands
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] ExtImmE;
   logic [XLEN-1:0] PCPlus4E;
   logic [XLEN-1:0] ResultW;
   logic [4:0]      Rs1E;
   logic [4:0]      Rs2E;
   logic [4:0]      RdE;
   // hazard controls
   logic [1:0]      ForwardAE;
   logic [1:0]      ForwardBE;
   logic            StallM;
   // M-stage outputs
   logic            RegWriteM;
   logic            MemWriteM;
   logic [1:0]      ResultSrcM;
   logic [1:0]      MemSizeM;
   logic [XLEN-1:0] ALUResultM;
   logic [XLEN-1:0] WriteDataM;
   logic [XLEN-1:0] PCPlus4M;
   logic [4:0]      RdM;
   logic            IsPerM;
   // E-stage outputs
   logic [XLEN-1:0] PCTargetE;
   logic            PCSrcE;
   logic            transEn;
   logic            MdBusyE;

   modport slave (
      input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, MemSizeE,
      input  ALUCtrlE, MdEnE, MdOpE, RD1E, RD2E, PCE, ExtImmE, PCPlus4E, ResultW,
      input  Rs1E, Rs2E, RdE, ForwardAE, ForwardBE, StallM,
      output RegWriteM, MemWriteM, ResultSrcM, MemSizeM, ALUResultM, WriteDataM,
      output PCPlus4M, RdM, IsPerM, PCTargetE, PCSrcE, transEn, MdBusyE
   );

   modport master (
      output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, MemSizeE,
      output ALUCtrlE, MdEnE, MdOpE, RD1E, RD2E, PCE, ExtImmE, PCPlus4E, ResultW,
      output Rs1E, Rs2E, RdE, ForwardAE, ForwardBE, StallM,
      input  RegWriteM, MemWriteM, ResultSrcM, MemSizeM, ALUResultM, WriteDataM,
      input  PCPlus4M, RdM, IsPerM, PCTargetE, PCSrcE, transEn, MdBusyE
   );
endinterface

// File: rtl/execute_stage_mdu.sv
// -----------------------------------------------------------------------------
// execute_stage_mdu
// RV32I execute stage with an iterative RV32M multiply/divide unit and the
// EX/MEM pipeline register.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : execute_stage_mdu_if.slave -- E-stage controls/operands, forwarding
//          selects, StallM in; M-stage register outputs, PCTargetE, PCSrcE,
//          transEn and MdBusyE out.
// Parameters:
//   XLEN     : datapath width
//   PER_BASE : lowest peripheral byte address (unsigned)
// ALUCtrlE encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU,
//                    7 SLL, 8 SRL, 9 SRA; other codes yield 0.
// The multiplier takes one cycle after issue; the divider is a restoring
// divider on operand magnitudes producing one quotient bit per cycle.
// -----------------------------------------------------------------------------
module execute_stage_mdu #(
   parameter int          XLEN     = 32,
   parameter int unsigned PER_BASE = 512
) (
   input logic                clk,
   input logic                rst,
   execute_stage_mdu_if.slave bus
);
   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(XLEN);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DIV  = 2'b10,
      S_DONE = 2'b11
   } md_state_e;

   // Two's-complement negate.
   function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
      return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   // ---------------------------------------------------------------- state
   md_state_e         state_q, state_d;
   logic [XLEN-1:0]   a_q, a_d;       // raw latched dividend / multiplicand
   logic [XLEN-1:0]   b_q, b_d;       // raw latched divisor / multiplier
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   quo_q, quo_d;   // dividend magnitude shifting out, quotient shifting in
   logic [XLEN-1:0]   rem_q, rem_d;   // partial remainder magnitude
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] prod_q, prod_d;

   logic              reg_write_q, reg_write_d;
   logic              mem_write_q, mem_write_d;
   logic [1:0]        result_src_q, result_src_d;
   logic [1:0]        mem_size_q, mem_size_d;
   logic [XLEN-1:0]   alu_result_q, alu_result_d;
   logic [XLEN-1:0]   write_data_q, write_data_d;
   logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;
   logic [4:0]        rd_q, rd_d;
   logic              is_per_q, is_per_d;

   // ------------------------------------------------------- combinational
   logic [XLEN-1:0]   src_a_s;
   logic [XLEN-1:0]   write_data_s;
   logic [XLEN-1:0]   src_b_s;
   logic [XLEN-1:0]   alu_out_s;
   logic [XLEN-1:0]   alu_result_e_s;
   logic [XLEN-1:0]   md_result_s;
   logic              md_busy_s;
   logic              is_per_e_s;
   logic              zero_s;

   logic              issue_signed_s;
   logic [XLEN-1:0]   issue_a_mag_s;
   logic              div_signed_s;
   logic              a_neg_s;
   logic              b_neg_s;
   logic [XLEN-1:0]   b_mag_s;
   logic [XLEN:0]     shift_s;
   logic [XLEN+1:0]   diff_s;
   logic              div_by_zero_s;
   logic              div_ovf_s;
   logic [2*XLEN-1:0] a_ext_s;
   logic [2*XLEN-1:0] b_ext_s;
   logic [2*XLEN-1:0] product_s;
   logic              unused_ok_s;

   // SrcA forwarding mux.
   always_comb begin
      src_a_s = {XLEN{1'b0}};
      case (bus.ForwardAE)
         2'b00:   src_a_s = bus.RD1E;
         2'b01:   src_a_s = bus.ResultW;
         2'b10:   src_a_s = alu_result_q;
         default: src_a_s = {XLEN{1'b0}};
      endcase
   end

   // WriteData forwarding mux.
   always_comb begin
      write_data_s = {XLEN{1'b0}};
      case (bus.ForwardBE)
         2'b00:   write_data_s = bus.RD2E;
         2'b01:   write_data_s = bus.ResultW;
         2'b10:   write_data_s = alu_result_q;
         default: write_data_s = {XLEN{1'b0}};
      endcase
   end

   assign src_b_s = bus.ALUSrcE ? bus.ExtImmE : write_data_s;

   // Integer ALU.
   always_comb begin
      alu_out_s = {XLEN{1'b0}};
      case (bus.ALUCtrlE)
         ALU_ADD:  alu_out_s = src_a_s + src_b_s;
         ALU_SUB:  alu_out_s = src_a_s - src_b_s;
         ALU_AND:  alu_out_s = src_a_s & src_b_s;
         ALU_OR:   alu_out_s = src_a_s | src_b_s;
         ALU_XOR:  alu_out_s = src_a_s ^ src_b_s;
         ALU_SLT:  alu_out_s = {{(XLEN-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
         ALU_SLTU: alu_out_s = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
         ALU_SLL:  alu_out_s = src_a_s << src_b_s[SHW-1:0];
         ALU_SRL:  alu_out_s = src_a_s >> src_b_s[SHW-1:0];
         ALU_SRA:  alu_out_s = $unsigned($signed(src_a_s) >>> src_b_s[SHW-1:0]);
         default:  alu_out_s = {XLEN{1'b0}};
      endcase
   end

   // Branch decision uses the ALU comparison, never the MDU result.
   assign zero_s        = (alu_out_s == {XLEN{1'b0}});
   assign bus.PCTargetE = bus.PCE + bus.ExtImmE;
   assign bus.PCSrcE    = (zero_s & bus.BranchE) | bus.JumpE;

   // ---------------------------------------------------------- MDU datapath
   assign issue_signed_s = (bus.MdOpE == MD_DIV) || (bus.MdOpE == MD_REM);
   assign issue_a_mag_s  = (issue_signed_s && src_a_s[XLEN-1]) ? neg_f(src_a_s) : src_a_s;

   assign div_signed_s  = (op_q == MD_DIV) || (op_q == MD_REM);
   assign a_neg_s       = div_signed_s & a_q[XLEN-1];
   assign b_neg_s       = div_signed_s & b_q[XLEN-1];
   assign b_mag_s       = b_neg_s ? neg_f(b_q) : b_q;
   assign div_by_zero_s = (b_q == {XLEN{1'b0}});
   assign div_ovf_s     = (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == {XLEN{1'b1}});

   // One restoring step: bring down the next dividend bit, try to subtract.
   assign shift_s = {rem_q, quo_q[XLEN-1]};
   assign diff_s  = {1'b0, shift_s} - {2'b00, b_mag_s};

   // Sign extension only for the operands MdOp treats as signed.
   assign a_ext_s   = ((op_q == MD_MULH) || (op_q == MD_MULHSU)) ?
                      {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
   assign b_ext_s   = (op_q == MD_MULH) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
   assign product_s = a_ext_s * b_ext_s;

   // MDU sequencing and next-state for its working registers.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      case (state_q)
         S_IDLE: begin
            if (bus.MdEnE) begin
               a_d     = src_a_s;
               b_d     = src_b_s;
               op_d    = bus.MdOpE;
               quo_d   = issue_a_mag_s;
               rem_d   = {XLEN{1'b0}};
               cnt_d   = {CW{1'b0}};
               state_d = bus.MdOpE[2] ? S_DIV : S_MUL;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            prod_d  = product_s;
            state_d = S_DONE;
         end
         S_DIV: begin
            if (diff_s[XLEN+1]) begin
               rem_d = shift_s[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end else begin
               rem_d = diff_s[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == CW'(XLEN-1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DIV;
            end
         end
         S_DONE: begin
            if (bus.StallM) begin
               state_d = S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // MDU result select with sign fix-up and the division corner cases.
   always_comb begin
      md_result_s = {XLEN{1'b0}};
      case (op_q)
         MD_MUL: md_result_s = prod_q[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: md_result_s = prod_q[2*XLEN-1:XLEN];
         MD_DIV: begin
            if (div_by_zero_s) begin
               md_result_s = {XLEN{1'b1}};
            end else if (div_ovf_s) begin
               md_result_s = a_q;
            end else if (a_neg_s ^ b_neg_s) begin
               md_result_s = neg_f(quo_q);
            end else begin
               md_result_s = quo_q;
            end
         end
         MD_DIVU: begin
            if (div_by_zero_s) begin
               md_result_s = {XLEN{1'b1}};
            end else begin
               md_result_s = quo_q;
            end
         end
         MD_REM: begin
            if (div_by_zero_s) begin
               md_result_s = a_q;
            end else if (div_ovf_s) begin
               md_result_s = {XLEN{1'b0}};
            end else if (a_neg_s) begin
               md_result_s = neg_f(rem_q);
            end else begin
               md_result_s = rem_q;
            end
         end
         MD_REMU: begin
            if (div_by_zero_s) begin
               md_result_s = a_q;
            end else begin
               md_result_s = rem_q;
            end
         end
         default: md_result_s = {XLEN{1'b0}};
      endcase
   end

   assign md_busy_s      = bus.MdEnE & (state_q != S_DONE);
   assign alu_result_e_s = (state_q == S_DONE) ? md_result_s : alu_out_s;
   assign is_per_e_s     = (bus.ResultSrcE[0] | bus.MemWriteE) &
                           (alu_result_e_s >= XLEN'(PER_BASE));
   assign bus.transEn    = is_per_e_s & ~md_busy_s;
   assign bus.MdBusyE    = md_busy_s;

   // EX/MEM next value: hold on stall, bubble the controls while the MDU works.
   always_comb begin
      reg_write_d  = reg_write_q;
      mem_write_d  = mem_write_q;
      result_src_d = result_src_q;
      mem_size_d   = mem_size_q;
      alu_result_d = alu_result_q;
      write_data_d = write_data_q;
      pc_plus4_d   = pc_plus4_q;
      rd_d         = rd_q;
      is_per_d     = is_per_q;
      if (bus.StallM) begin
         reg_write_d = reg_write_q;
      end else begin
         mem_size_d   = bus.MemSizeE;
         alu_result_d = alu_result_e_s;
         write_data_d = write_data_s;
         pc_plus4_d   = bus.PCPlus4E;
         rd_d         = bus.RdE;
         if (md_busy_s) begin
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            result_src_d = 2'b00;
            is_per_d     = 1'b0;
         end else begin
            reg_write_d  = bus.RegWriteE;
            mem_write_d  = bus.MemWriteE;
            result_src_d = bus.ResultSrcE;
            is_per_d     = is_per_e_s;
         end
      end
   end

   // MDU state and EX/MEM register; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         a_q          <= {XLEN{1'b0}};
         b_q          <= {XLEN{1'b0}};
         op_q         <= 3'b000;
         quo_q        <= {XLEN{1'b0}};
         rem_q        <= {XLEN{1'b0}};
         cnt_q        <= {CW{1'b0}};
         prod_q       <= {(2*XLEN){1'b0}};
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         result_src_q <= 2'b00;
         mem_size_q   <= 2'b00;
         alu_result_q <= {XLEN{1'b0}};
         write_data_q <= {XLEN{1'b0}};
         pc_plus4_q   <= {XLEN{1'b0}};
         rd_q         <= 5'd0;
         is_per_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         quo_q        <= quo_d;
         rem_q        <= rem_d;
         cnt_q        <= cnt_d;
         prod_q       <= prod_d;
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         result_src_q <= result_src_d;
         mem_size_q   <= mem_size_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         pc_plus4_q   <= pc_plus4_d;
         rd_q         <= rd_d;
         is_per_q     <= is_per_d;
      end
   end

   assign bus.RegWriteM  = reg_write_q;
   assign bus.MemWriteM  = mem_write_q;
   assign bus.ResultSrcM = result_src_q;
   assign bus.MemSizeM   = mem_size_q;
   assign bus.ALUResultM = alu_result_q;
   assign bus.WriteDataM = write_data_q;
   assign bus.PCPlus4M   = pc_plus4_q;
   assign bus.RdM        = rd_q;
   assign bus.IsPerM     = is_per_q;

   // Source indices feed the hazard unit, not this stage.
   assign unused_ok_s = ^{bus.Rs1E, bus.Rs2E, diff_s[XLEN]};

endmodule

// File: tb/tb_execute_stage_mdu.sv
// -----------------------------------------------------------------------------
// tb_execute_stage_mdu
// Directed-vector bench for execute_stage_mdu: forwarding/ALU, branch target,
// peripheral decode, all RV32M ops including divide corner cases, busy-cycle
// counts, bubbles, operand isolation, reset mid-divide and DONE stall hold.
// -----------------------------------------------------------------------------
module tb_execute_stage_mdu;
   localparam int XLEN = 32;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   execute_stage_mdu_if #(.XLEN(XLEN)) bus ();

   execute_stage_mdu #(.XLEN(XLEN), .PER_BASE(512)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_defaults();
      bus.RegWriteE  = 1'b0;
      bus.MemWriteE  = 1'b0;
      bus.JumpE      = 1'b0;
      bus.BranchE    = 1'b0;
      bus.ALUSrcE    = 1'b0;
      bus.ResultSrcE = 2'b00;
      bus.MemSizeE   = 2'b00;
      bus.ALUCtrlE   = ALU_ADD;
      bus.MdEnE      = 1'b0;
      bus.MdOpE      = 3'b000;
      bus.RD1E       = 32'h0;
      bus.RD2E       = 32'h0;
      bus.PCE        = 32'h0;
      bus.ExtImmE    = 32'h0;
      bus.PCPlus4E   = 32'h0;
      bus.ResultW    = 32'h0;
      bus.Rs1E       = 5'd0;
      bus.Rs2E       = 5'd0;
      bus.RdE        = 5'd0;
      bus.ForwardAE  = 2'b00;
      bus.ForwardBE  = 2'b00;
      bus.StallM     = 1'b0;
   endtask

   // Counts rising edges while MdBusyE is high; flags any non-bubble write.
   task automatic wait_busy(input bit scramble, output int n, output logic saw_wr);
      n      = 0;
      saw_wr = 1'b0;
      while (bus.MdBusyE && n < 100) begin
         tick();
         n++;
         saw_wr = saw_wr | bus.RegWriteM;
         if (scramble) begin
            bus.ForwardAE = 2'b11;
            bus.ForwardBE = 2'b11;
            bus.RD1E      = 32'h5A5A5A5A;
            bus.RD2E      = 32'hA5A5A5A5;
         end
         #1;
      end
   endtask

   task automatic run_mdu(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_busy);
      int   n;
      logic saw_wr;
      set_defaults();
      bus.RD1E      = a;
      bus.RD2E      = b;
      bus.MdEnE     = 1'b1;
      bus.MdOpE     = op;
      bus.RegWriteE = 1'b1;
      bus.RdE       = 5'd9;
      #1;
      wait_busy(1'b1, n, saw_wr);
      check_value({tag, "_busy"}, 64'(n), 64'(exp_busy));
      check_value({tag, "_bubble"}, 64'(saw_wr), 64'h0);
      tick();
      check_value({tag, "_res"}, 64'(bus.ALUResultM), 64'(exp));
      check_value({tag, "_wr"}, 64'(bus.RegWriteM), 64'h1);
      set_defaults();
   endtask

   initial begin
      int   n;
      logic saw_wr;

      // ---------------- reset state
      set_defaults();
      rst = 1'b1;
      bus.RD1E      = 32'h55;
      bus.RegWriteE = 1'b1;
      tick();
      tick();
      check_value("rst_alum",  64'(bus.ALUResultM), 64'h0);
      check_value("rst_regw",  64'(bus.RegWriteM), 64'h0);
      check_value("rst_isper", 64'(bus.IsPerM), 64'h0);
      check_value("rst_busy",  64'(bus.MdBusyE), 64'h0);
      rst = 1'b0;
      set_defaults();

      // ---------------- ALU with forwarding
      bus.RD1E      = 32'h10;
      bus.RegWriteE = 1'b1;
      bus.RdE       = 5'd3;
      tick();
      check_value("alu_seed", 64'(bus.ALUResultM), 64'h10);
      check_value("alu_rd",   64'(bus.RdM), 64'h3);
      bus.ForwardAE = 2'b10;
      bus.RD1E      = 32'hDEAD;
      bus.RD2E      = 32'h5;
      #1;
      check_value("fwd_busy", 64'(bus.MdBusyE), 64'h0);
      tick();
      check_value("fwd_m_add", 64'(bus.ALUResultM), 64'h15);
      check_value("fwd_wdata", 64'(bus.WriteDataM), 64'h5);

      // ---------------- branch / jump
      set_defaults();
      bus.ForwardAE = 2'b01;
      bus.ResultW   = 32'h30;
      bus.ALUSrcE   = 1'b1;
      bus.ExtImmE   = 32'h30;
      bus.ALUCtrlE  = ALU_SUB;
      bus.BranchE   = 1'b1;
      bus.PCE       = 32'h100;
      #1;
      check_value("br_taken",  64'(bus.PCSrcE), 64'h1);
      check_value("br_target", 64'(bus.PCTargetE), 64'h130);
      bus.ExtImmE = 32'h20;
      #1;
      check_value("br_not",     64'(bus.PCSrcE), 64'h0);
      check_value("br_target2", 64'(bus.PCTargetE), 64'h120);
      bus.JumpE = 1'b1;
      #1;
      check_value("jump", 64'(bus.PCSrcE), 64'h1);

      // ---------------- ForwardBE=11 zeroes WriteData; StallM holds EX/MEM
      set_defaults();
      bus.RD1E      = 32'h7;
      bus.RD2E      = 32'h99;
      bus.ForwardBE = 2'b11;
      tick();
      check_value("fwdb_zero_alu", 64'(bus.ALUResultM), 64'h7);
      check_value("fwdb_zero_wd",  64'(bus.WriteDataM), 64'h0);
      bus.StallM = 1'b1;
      bus.RD1E   = 32'h1234;
      tick();
      check_value("stall_hold", 64'(bus.ALUResultM), 64'h7);

      // ---------------- peripheral decode boundary
      set_defaults();
      bus.MemWriteE = 1'b1;
      bus.RD1E      = 32'h200;
      #1;
      check_value("per_trans_hi", 64'(bus.transEn), 64'h1);
      tick();
      check_value("per_isper_hi", 64'(bus.IsPerM), 64'h1);
      bus.RD1E = 32'h1FF;
      #1;
      check_value("per_trans_lo", 64'(bus.transEn), 64'h0);
      tick();
      check_value("per_isper_lo", 64'(bus.IsPerM), 64'h0);
      set_defaults();
      bus.ResultSrcE = 2'b01;
      bus.RD1E       = 32'h300;
      #1;
      check_value("per_load", 64'(bus.transEn), 64'h1);
      set_defaults();

      // ---------------- RV32M
      run_mdu("mulhu",  MD_MULHU,  32'hFFFFFFFF, 32'h2, 32'h1, 2);
      run_mdu("mul",    MD_MUL,    32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 2);
      run_mdu("mulh",   MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 2);
      run_mdu("mulhsu", MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
      run_mdu("mulhu2", MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
      run_mdu("div",    MD_DIV,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
      run_mdu("rem",    MD_REM,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
      run_mdu("div_nb", MD_DIV,    32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
      run_mdu("rem_nb", MD_REM,    32'h7, 32'hFFFFFFFE, 32'h1, 33);
      run_mdu("divu",   MD_DIVU,   32'd100, 32'd7, 32'd14, 33);
      run_mdu("remu",   MD_REMU,   32'd100, 32'd7, 32'd2, 33);
      run_mdu("divu_z", MD_DIVU,   32'h1234, 32'h0, 32'hFFFFFFFF, 33);
      run_mdu("remu_z", MD_REMU,   32'h1234, 32'h0, 32'h1234, 33);
      run_mdu("rem_ov", MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0, 33);
      run_mdu("div_ov", MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);

      // ---------------- reset mid-divide, restart, DONE stall hold
      set_defaults();
      bus.RD1E      = 32'hFFFFFFF9;
      bus.RD2E      = 32'h2;
      bus.MdEnE     = 1'b1;
      bus.MdOpE     = MD_DIV;
      bus.RegWriteE = 1'b1;
      bus.RdE       = 5'd9;
      bus.PCPlus4E  = 32'h44;
      repeat (10) tick();
      check_value("mid_busy",  64'(bus.MdBusyE), 64'h1);
      check_value("mid_alum",  64'(bus.ALUResultM), 64'hFFFFFFFB);
      check_value("mid_pc4",   64'(bus.PCPlus4M), 64'h44);
      rst = 1'b1;
      #1;
      check_value("rstmid_alum", 64'(bus.ALUResultM), 64'h0);
      check_value("rstmid_pc4",  64'(bus.PCPlus4M), 64'h0);
      check_value("rstmid_wd",   64'(bus.WriteDataM), 64'h0);
      check_value("rstmid_rd",   64'(bus.RdM), 64'h0);
      tick();
      rst = 1'b0;
      #1;
      wait_busy(1'b0, n, saw_wr);
      check_value("restart_busy", 64'(n), 64'd33);
      bus.StallM = 1'b1;
      repeat (3) tick();
      check_value("done_hold_alum", 64'(bus.ALUResultM), 64'hFFFFFFFB);
      check_value("done_hold_busy", 64'(bus.MdBusyE), 64'h0);
      bus.StallM = 1'b0;
      tick();
      check_value("done_release", 64'(bus.ALUResultM), 64'hFFFFFFFD);
      set_defaults();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
